// File: rtl/corr_window_engine.sv
// Window correlation engine: sums frame*template over a T_W x T_H window
// anchored at (iX,iY). Frame and template are read from synchronous RAMs.
module corr_window_engine #(
    parameter int H_RES   = 640,
    parameter int V_RES   = 480,
    parameter int T_W     = 32,
    parameter int T_H     = 32,
    parameter int ADDR_W  = 20,
    parameter int TADDR_W = 10
) (
    input  logic               iCLK,
    input  logic               iRST_N,
    input  logic               iStart,
    input  logic [12:0]        iX,
    input  logic [12:0]        iY,
    output logic [ADDR_W-1:0]  oFrameAddr,
    output logic               oFrameRd,
    input  logic [7:0]         iFramePixel,
    output logic [TADDR_W-1:0] oTmplAddr,
    input  logic [7:0]         iTmplPixel,
    output logic               oBusy,
    output logic               oCorrFinished,
    output logic [31:0]        oCorrValue
);

    localparam int TXW = (T_W > 1) ? $clog2(T_W) : 1;
    localparam int TYW = (T_H > 1) ? $clog2(T_H) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t           state;
    logic [12:0]      xLatch;
    logic [12:0]      yLatch;
    logic [TXW-1:0]   tx;
    logic [TYW-1:0]   ty;
    logic             rdValid;
    logic             drainLast;
    logic [31:0]      acc;

    logic [12:0]      selX;
    logic [12:0]      selY;
    logic [TXW-1:0]   selTx;
    logic [TYW-1:0]   selTy;
    logic [TXW-1:0]   nextTx;
    logic [TYW-1:0]   nextTy;
    logic             lastSel;
    logic [31:0]      px;
    logic [31:0]      py;
    logic             inRange;
    logic [ADDR_W-1:0]  frameAddrNext;
    logic [TADDR_W-1:0] tmplAddrNext;
    logic [15:0]      product;
    logic [31:0]      accNext;

    // In IDLE the first address is issued straight from the start inputs so
    // element 0 appears the cycle after iStart is sampled.
    always_comb begin
        selX  = (state == IDLE) ? iX : xLatch;
        selY  = (state == IDLE) ? iY : yLatch;
        selTx = (state == IDLE) ? '0 : tx;
        selTy = (state == IDLE) ? '0 : ty;

        lastSel = (selTx == TXW'(T_W - 1)) && (selTy == TYW'(T_H - 1));
        if (selTx == TXW'(T_W - 1)) begin
            nextTx = '0;
            nextTy = selTy + 1'b1;
        end else begin
            nextTx = selTx + 1'b1;
            nextTy = selTy;
        end

        px      = 32'(selX) + 32'(selTx);
        py      = 32'(selY) + 32'(selTy);
        inRange = (px < 32'(H_RES)) && (py < 32'(V_RES));
        frameAddrNext = ADDR_W'(py * 32'(H_RES) + px);
        tmplAddrNext  = TADDR_W'(32'(selTy) * 32'(T_W) + 32'(selTx));

        product = iFramePixel * iTmplPixel;
        accNext = acc + (rdValid ? {16'h0000, product} : 32'h0);
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state         <= IDLE;
            xLatch        <= '0;
            yLatch        <= '0;
            tx            <= '0;
            ty            <= '0;
            rdValid       <= 1'b0;
            drainLast     <= 1'b0;
            acc           <= '0;
            oFrameAddr    <= '0;
            oFrameRd      <= 1'b0;
            oTmplAddr     <= '0;
            oBusy         <= 1'b0;
            oCorrFinished <= 1'b0;
            oCorrValue    <= '0;
        end else begin
            rdValid <= oFrameRd;
            acc     <= accNext;
            case (state)
                IDLE: begin
                    oCorrFinished <= 1'b0;
                    if (iStart) begin
                        xLatch     <= iX;
                        yLatch     <= iY;
                        acc        <= '0;
                        oBusy      <= 1'b1;
                        oFrameRd   <= inRange;
                        oFrameAddr <= inRange ? frameAddrNext : '0;
                        oTmplAddr  <= tmplAddrNext;
                        tx         <= nextTx;
                        ty         <= nextTy;
                        state      <= lastSel ? DRAIN : RUN;
                    end
                end
                RUN: begin
                    oFrameRd   <= inRange;
                    oFrameAddr <= inRange ? frameAddrNext : '0;
                    oTmplAddr  <= tmplAddrNext;
                    tx         <= nextTx;
                    ty         <= nextTy;
                    if (lastSel) begin
                        state <= DRAIN;
                    end
                end
                // Two drain edges: one for the RAM read latency, one for the
                // final accumulate, which is folded into the result register.
                DRAIN: begin
                    oFrameRd   <= 1'b0;
                    oFrameAddr <= '0;
                    oTmplAddr  <= '0;
                    tx         <= '0;
                    ty         <= '0;
                    if (drainLast) begin
                        drainLast     <= 1'b0;
                        oCorrValue    <= accNext;
                        oCorrFinished <= 1'b1;
                        oBusy         <= 1'b0;
                        state         <= DONE;
                    end else begin
                        drainLast <= 1'b1;
                    end
                end
                DONE: begin
                    oCorrFinished <= 1'b0;
                    state         <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_corr_window_engine.sv
// Scoreboard bench for corr_window_engine: constant-valued RAM models,
// directed origins, per-cycle address model and result/latency checks.
module tb_corr_window_engine;

    localparam int H  = 640;
    localparam int V  = 480;
    localparam int TW = 32;
    localparam int TH = 32;
    localparam int N  = TW * TH;

    logic        clk = 1'b0;
    logic        rstN = 1'b0;
    logic        start = 1'b0;
    logic [12:0] xIn = '0;
    logic [12:0] yIn = '0;
    logic [19:0] frameAddr;
    logic        frameRd;
    logic [7:0]  framePixel = '0;
    logic [9:0]  tmplAddr;
    logic [7:0]  tmplPixel = '0;
    logic        busy;
    logic        finished;
    logic [31:0] corrValue;

    logic [7:0]  frameVal = 8'd0;
    logic [7:0]  tmplVal = 8'd0;

    corr_window_engine #(
        .H_RES(H), .V_RES(V), .T_W(TW), .T_H(TH), .ADDR_W(20), .TADDR_W(10)
    ) dut (
        .iCLK(clk), .iRST_N(rstN), .iStart(start), .iX(xIn), .iY(yIn),
        .oFrameAddr(frameAddr), .oFrameRd(frameRd), .iFramePixel(framePixel),
        .oTmplAddr(tmplAddr), .iTmplPixel(tmplPixel), .oBusy(busy),
        .oCorrFinished(finished), .oCorrValue(corrValue)
    );

    always #10 clk = ~clk;

    // Synchronous RAM models; unread frame data is junk so ignored reads show up.
    always @(posedge clk) begin
        framePixel <= frameRd ? frameVal : 8'hA5;
        tmplPixel  <= tmplVal;
    end

    typedef struct {
        logic [31:0] value;
        int          reads;
    } exp_t;
    exp_t q[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int pushes = 0;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input longint act, input longint req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // Monitor state
    logic pendAccept = 1'b0;
    int   pendX = 0;
    int   pendY = 0;
    logic modelActive = 1'b0;
    int   mX = 0, mY = 0, k = 0, reads = 0, addrBad = 0, startEdge = 0;
    int   doneCount = 0;

    always @(negedge clk) begin
        if (!rstN) begin
            modelActive = 1'b0;
        end else begin
            if (pendAccept) begin
                pendAccept  = 1'b0;
                modelActive = 1'b1;
                mX = pendX; mY = pendY;
                k = 0; reads = 0; addrBad = 0;
                startEdge = cyc;
            end
            if (modelActive && k < N) begin
                int tx, ty, px, py;
                logic inr;
                logic [19:0] expA;
                tx  = k % TW;
                ty  = k / TW;
                px  = mX + tx;
                py  = mY + ty;
                inr = (px < H) && (py < V);
                expA = inr ? 20'(py * H + px) : 20'd0;
                if (tmplAddr !== 10'(k) || frameRd !== inr || frameAddr !== expA) addrBad++;
                k++;
            end
            if (frameRd) reads++;
            if (finished) begin
                exp_t e;
                doneCount++;
                if (q.size() == 0) begin
                    check("unexpected_pulse", 1, 0);
                end else begin
                    e = q.pop_front();
                    check("value", corrValue, e.value);
                    check("reads", reads, e.reads);
                    check("latency", cyc - startEdge + 1, N + 2);
                    check("addr_seq_errs", addrBad, 0);
                    check("busy_at_done", busy, 0);
                end
                modelActive = 1'b0;
            end
        end
    end

    task automatic runStart(input int x, input int y, input int fv, input int tv,
                            input longint expVal, input int expReads, input bit push);
        exp_t e;
        @(negedge clk); #1;
        frameVal = 8'(fv);
        tmplVal  = 8'(tv);
        xIn = 13'(x);
        yIn = 13'(y);
        start = 1'b1;
        pendX = x; pendY = y;
        pendAccept = 1'b1;
        if (push) begin
            e.value = 32'(expVal);
            e.reads = expReads;
            q.push_back(e);
            pushes++;
        end
        @(negedge clk); #1;
        start = 1'b0;
    endtask

    task automatic waitDone();
        int d0 = doneCount;
        int n = 0;
        while (doneCount == d0 && n < 3000) begin
            @(negedge clk); #1;
            n++;
        end
        check("finished_seen", doneCount - d0, 1);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_rd", frameRd, 0);
        check("rst_value", corrValue, 0);
        check("rst_fin", finished, 0);
        rstN = 1'b1;

        runStart(0, 0, 1, 1, 1024, 1024, 1);              waitDone();
        runStart(0, 0, 255, 255, 66585600, 1024, 1);      waitDone();
        runStart(H - 16, 0, 1, 1, 512, 512, 1);           waitDone();
        runStart(H, V, 9, 9, 0, 0, 1);                    waitDone();

        // start pulses while busy must be ignored
        runStart(100, 50, 3, 2, 6144, 1024, 1);
        repeat (10) @(negedge clk);
        #1; start = 1'b1; xIn = 13'd0; yIn = 13'd0;
        @(negedge clk); #1; start = 1'b0;
        waitDone();

        runStart(H - 1, V - 1, 200, 100, 20000, 1, 1);    waitDone();
        runStart(0, V - 8, 1, 1, 256, 256, 1);            waitDone();

        // reset mid-run: no pulse, everything back to zero
        runStart(0, 0, 1, 1, 0, 0, 0);
        repeat (200) @(negedge clk);
        #5; rstN = 1'b0;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_rd", frameRd, 0);
        check("midrst_addr", frameAddr, 0);
        check("midrst_tmpl", tmplAddr, 0);
        check("midrst_value", corrValue, 0);
        repeat (3) @(negedge clk);
        #1; rstN = 1'b1;
        runStart(10, 20, 2, 7, 14336, 1024, 1);           waitDone();

        repeat (50) @(negedge clk);
        check("queue_empty", q.size(), 0);
        check("pulse_count", doneCount, pushes);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
